// File: rtl/router_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : router_ctrl
//  Description : Packet write controller for three router output FIFOs.
//                Decodes the header byte (dest in [1:0], payload length in
//                [7:2]), steers bytes to one FIFO with a first-byte tag,
//                applies backpressure, checks packet parity and soft-resets
//                any FIFO left non-empty and unread for TIMEOUT cycles.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                pkt_valid, din      - input byte stream
//                fifo_full/empty     - per-FIFO status flags
//                rd_en               - downstream reads (timeout only)
//                busy                - backpressure (combinational)
//                wr_en, lfd_state    - one-hot write, header tag (comb.)
//                data_out            - byte to FIFOs (combinational)
//                parity_err          - registered parity mismatch flag
//                soft_rst            - registered per-FIFO soft-reset pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module router_ctrl #(
    parameter int TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [7:0] din,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] rd_en,
    output logic       busy,
    output logic [2:0] wr_en,
    output logic       lfd_state,
    output logic [7:0] data_out,
    output logic       parity_err,
    output logic [2:0] soft_rst
);

    localparam int         c_CNT_W     = $clog2(TIMEOUT);
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_WAIT   = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [1:0] r_addr;
    logic [7:0] r_hdr;
    logic [5:0] r_rem;
    logic [7:0] r_par;

    logic [1:0] w_dest;
    logic       w_hdr_ok;
    logic       w_busy;
    logic       w_accept;

    assign w_dest   = din[1:0];
    assign w_hdr_ok = (w_dest != 2'd3);

    // Backpressure depends only on state and the flags of the latched FIFO,
    // never on the write decision, so it can feed w_accept without a loop.
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            c_ST_WAIT:               w_busy = 1'b1;
            c_ST_DATA, c_ST_PARITY:  w_busy = fifo_full[r_addr];
            default:                 w_busy = 1'b0;
        endcase
    end

    assign busy     = w_busy;
    assign w_accept = pkt_valid & ~w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        wr_en     = 3'b000;
        lfd_state = 1'b0;
        data_out  = din;
        case (r_state)
            c_ST_IDLE: begin
                if (pkt_valid && w_hdr_ok) begin
                    if (fifo_empty[w_dest]) begin
                        wr_en     = 3'b001 << w_dest;
                        lfd_state = 1'b1;
                        w_next    = (din[7:2] == 6'd0) ? c_ST_PARITY : c_ST_DATA;
                    end else begin
                        w_next = c_ST_WAIT;
                    end
                end
            end
            c_ST_WAIT: begin
                // The stored header is presented for the whole wait so it
                // is on data_out the moment the FIFO reports empty.
                data_out = r_hdr;
                if (fifo_empty[r_addr]) begin
                    wr_en     = 3'b001 << r_addr;
                    lfd_state = 1'b1;
                    w_next    = (r_rem == 6'd0) ? c_ST_PARITY : c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_accept) begin
                    wr_en = 3'b001 << r_addr;
                    if (r_rem == 6'd1) begin
                        w_next = c_ST_PARITY;
                    end
                end
                // A soft reset of the target FIFO abandons the packet; the
                // remaining bytes are swallowed in DRAIN.
                if (soft_rst[r_addr]) begin
                    w_next = c_ST_DRAIN;
                end
            end
            c_ST_PARITY: begin
                if (w_accept) begin
                    wr_en  = 3'b001 << r_addr;
                    w_next = c_ST_IDLE;
                end
                if (soft_rst[r_addr]) begin
                    w_next = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_accept && (r_rem == 6'd0)) begin
                    w_next = c_ST_IDLE;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= 2'd0;
            r_hdr      <= 8'd0;
            r_rem      <= 6'd0;
            r_par      <= 8'd0;
            parity_err <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept && w_hdr_ok) begin
                        r_addr     <= w_dest;
                        r_hdr      <= din;
                        r_rem      <= din[7:2];
                        r_par      <= din;
                        parity_err <= 1'b0;
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_par <= r_par ^ din;
                        r_rem <= r_rem - 6'd1;
                    end
                end
                c_ST_PARITY: begin
                    if (w_accept) begin
                        parity_err <= (din != r_par);
                    end
                end
                c_ST_DRAIN: begin
                    // r_rem counts payload left; the extra parity byte is the
                    // one accepted while r_rem is already zero.
                    if (w_accept && (r_rem != 6'd0)) begin
                        r_rem <= r_rem - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar k = 0; k < 3; k++) begin : g_timeout
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_pulse;
            logic               w_stale;

            assign w_stale = ~fifo_empty[k] & ~rd_en[k];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end else if (w_stale && (r_cnt == c_CNT_W'(TIMEOUT - 1))) begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b1;
                end else if (w_stale) begin
                    r_cnt   <= r_cnt + c_CNT_W'(1);
                    r_pulse <= 1'b0;
                end else begin
                    r_cnt   <= '0;
                    r_pulse <= 1'b0;
                end
            end

            assign soft_rst[k] = r_pulse;
        end
    endgenerate

endmodule
`default_nettype wire
